svreal_mul_sched: RTL and testbench

//  Shares one pipelined fixed-point multiplier (c = a*b, svreal fixed-point formats)

---
 rtl/svreal_mul_sched.sv | 141 ++++++++++++++
 tb/tb_svreal_mul_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/svreal_mul_sched.sv
// Round-robin scheduler that shares one pipelined fixed-point multiplier among N_REQ
// requesters; responses leave in issue order, tagged with the requester index.
module svreal_mul_sched #(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = 16,
  parameter int A_EXP   = -8,
  parameter int B_WIDTH = 17,
  parameter int B_EXP   = -9,
  parameter int C_WIDTH = 18,
  parameter int C_EXP   = -10,
  parameter int PIPE    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*A_WIDTH-1:0]       req_a,
  input  logic [N_REQ*B_WIDTH-1:0]       req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(N_REQ)-1:0]       rsp_id,
  output logic [C_WIDTH-1:0]             rsp_c,
  output logic [$clog2(PIPE+2)-1:0]      inflight
);

  localparam int IDW = $clog2(N_REQ);
  localparam int IFW = $clog2(PIPE + 2);
  localparam int PW  = A_WIDTH + B_WIDTH;
  localparam int EW  = PW + C_WIDTH;
  localparam int SH  = (A_EXP + B_EXP) - C_EXP;
  localparam int SHR = (SH < 0) ? -SH : 0;
  localparam int SHL = (SH > 0) ? SH : 0;

  logic [IDW-1:0]              rrPtr_q, rrPtr_d;
  logic [IFW-1:0]              inflight_q, inflight_d;
  logic                        v0_q;
  logic [IDW-1:0]              id0_q;
  logic signed [A_WIDTH-1:0]   a0_q;
  logic signed [B_WIDTH-1:0]   b0_q;
  logic                        vPipe_q  [1:PIPE];
  logic [IDW-1:0]              idPipe_q [1:PIPE];
  logic [C_WIDTH-1:0]          cPipe_q  [1:PIPE];

  logic                        adv, pop, grant, grantAny;
  logic [IDW-1:0]              grantIdx;
  logic [IDW:0]                cand;
  logic [A_WIDTH-1:0]          selA;
  logic [B_WIDTH-1:0]          selB;
  logic signed [PW-1:0]        prodFull;
  logic signed [EW-1:0]        prodExt, prodShift;
  logic [C_WIDTH-1:0]          prodC;

  assign rsp_valid = vPipe_q[PIPE];
  assign rsp_id    = idPipe_q[PIPE];
  assign rsp_c     = cPipe_q[PIPE];
  assign inflight  = inflight_q;

  // Any held response freezes the whole pipe, which also blocks new grants.
  assign adv = !rsp_valid || rsp_ready;
  assign pop = rsp_valid && rsp_ready;

  always_comb begin
    grantAny  = 1'b0;
    grantIdx  = '0;
    cand      = '0;
    req_ready = '0;
    selA      = '0;
    selB      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rrPtr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (!grantAny && req_valid[cand[IDW-1:0]]) begin
        grantAny = 1'b1;
        grantIdx = cand[IDW-1:0];
      end
    end
    grant = en && adv && rst_n && grantAny;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant && (grantIdx == IDW'(i));
      if (grantIdx == IDW'(i)) begin
        selA = req_a[i*A_WIDTH +: A_WIDTH];
        selB = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (grant) rrPtr_d = (grantIdx == IDW'(N_REQ-1)) ? '0 : grantIdx + IDW'(1);
    inflight_d = inflight_q;
    if (grant && !pop) inflight_d = inflight_q + IFW'(1);
    else if (!grant && pop) inflight_d = inflight_q - IFW'(1);
  end

  // Rescale to the C exponent with floor rounding, then wrap into C_WIDTH bits.
  always_comb begin
    prodFull  = PW'(a0_q) * PW'(b0_q);
    prodExt   = EW'(prodFull);
    prodShift = (prodExt >>> SHR) <<< SHL;
    prodC     = C_WIDTH'(prodShift);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q    <= '0;
      inflight_q <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q  <= 1'b0;
      id0_q <= '0;
      a0_q  <= '0;
      b0_q  <= '0;
      for (int s = 1; s <= PIPE; s++) begin
        vPipe_q[s]  <= 1'b0;
        idPipe_q[s] <= '0;
        cPipe_q[s]  <= '0;
      end
    end else if (adv) begin
      v0_q        <= grant;
      id0_q       <= grantIdx;
      a0_q        <= selA;
      b0_q        <= selB;
      vPipe_q[1]  <= v0_q;
      idPipe_q[1] <= id0_q;
      cPipe_q[1]  <= prodC;
      for (int s = 2; s <= PIPE; s++) begin
        vPipe_q[s]  <= vPipe_q[s-1];
        idPipe_q[s] <= idPipe_q[s-1];
        cPipe_q[s]  <= cPipe_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_svreal_mul_sched.sv
// Directed bench for svreal_mul_sched: arbitration order, latency, backpressure,
// arithmetic corner cases, drain and mid-operation reset.
module tb_svreal_mul_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [67:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [17:0] rsp_c;
  logic [1:0]  inflight;

  int testCount = 0;
  int failCount = 0;

  svreal_mul_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .inflight(inflight)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResponse(input string tag, input logic v, input logic [1:0] id, input logic [17:0] c);
    checkOutput({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    checkOutput({tag, ".id"}, 32'(rsp_id), 32'(id));
    checkOutput({tag, ".c"}, 32'(rsp_c), 32'(c));
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic enable, input logic ready);
    req_valid = valid;
    en        = enable;
    rsp_ready = ready;
    #1;
  endtask

  task automatic setOperand(input int i, input logic [15:0] a, input logic [16:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*17 +: 17] = b;
  endtask

  task automatic stepEdge;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset;
    rst_n = 1'b0;
    req_valid = '0;
    stepEdge;
    stepEdge;
    rst_n = 1'b1;
    #1;
  endtask

  logic [3:0] t6Valid [10] = '{4'b1001, 4'b1000, 4'b0100, 4'b0100, 4'b0100,
                               4'b0010, 4'b1111, 4'b1011, 4'b0011, 4'b0010};
  logic [3:0] t6Ready [10] = '{4'b0001, 4'b1000, 4'b0100, 4'b0100, 4'b0100,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int         t6Ids   [10] = '{0, 3, 2, 2, 2, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0; en = 1'b1; rsp_ready = 1'b1;
    req_valid = 4'b1111; req_a = '0; req_b = '0;
    stepEdge;
    stepEdge;
    checkResponse("reset", 1'b0, 2'd0, 18'd0);
    checkOutput("reset inflight", 32'(inflight), 32'd0);
    checkOutput("reset ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    #1;

    // Basic single op: 314*2335 = 733190, >>>7 = 5728
    setOperand(0, 16'd314, 17'd2335);
    applyStimulus(4'b0001, 1'b1, 1'b1);
    checkOutput("t1 ready", 32'(req_ready), 32'b0001);
    stepEdge;
    req_valid = '0;
    checkOutput("t1 inflight1", 32'(inflight), 32'd1);
    checkOutput("t1 early0", 32'(rsp_valid), 32'd0);
    stepEdge;
    checkOutput("t1 early1", 32'(rsp_valid), 32'd0);
    stepEdge;
    checkResponse("t1 rsp", 1'b1, 2'd0, 18'd5728);
    stepEdge;
    checkOutput("t1 done valid", 32'(rsp_valid), 32'd0);
    checkOutput("t1 done inflight", 32'(inflight), 32'd0);

    // Fairness: requester i computes (i+1)*1.0 * 1.0 -> (i+1)*1024
    applyReset;
    for (int i = 0; i < 4; i++) setOperand(i, 16'((i + 1) * 256), 17'd512);
    for (int n = 0; n < 10; n++) begin
      if (n < 8) begin
        applyStimulus(4'b1111, 1'b1, 1'b1);
        checkOutput($sformatf("t2 grant%0d", n), 32'(req_ready), 32'(1 << (n % 4)));
      end else begin
        applyStimulus(4'b0000, 1'b1, 1'b1);
      end
      stepEdge;
      if (n == 1) checkOutput("t2 none yet", 32'(rsp_valid), 32'd0);
      if (n >= 2) checkResponse($sformatf("t2 rsp%0d", n - 2), 1'b1, 2'((n - 2) % 4), 18'(((n - 2) % 4 + 1) * 1024));
      if (n == 5) checkOutput("t2 inflight", 32'(inflight), 32'd3);
    end
    stepEdge;
    checkOutput("t2 drained valid", 32'(rsp_valid), 32'd0);
    checkOutput("t2 drained inflight", 32'(inflight), 32'd0);

    // Backpressure: three ops fill the pipe, then everything holds
    applyReset;
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput($sformatf("t3 ready%0d", n), 32'(req_ready), (n < 3) ? 32'(1 << n) : 32'd0);
      stepEdge;
      if (n >= 2) begin
        checkResponse($sformatf("t3 hold%0d", n), 1'b1, 2'd0, 18'd1024);
        checkOutput($sformatf("t3 inflight%0d", n), 32'(inflight), 32'd3);
      end
    end
    applyStimulus(4'b1000, 1'b1, 1'b1);
    checkOutput("t3 resume ready", 32'(req_ready), 32'b1000);
    stepEdge;
    checkResponse("t3 rsp1", 1'b1, 2'd1, 18'd2048);
    checkOutput("t3 inflight swap", 32'(inflight), 32'd3);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepEdge;
    checkResponse("t3 rsp2", 1'b1, 2'd2, 18'd3072);
    stepEdge;
    checkResponse("t3 rsp3", 1'b1, 2'd3, 18'd4096);
    checkOutput("t3 inflight1", 32'(inflight), 32'd1);
    stepEdge;
    checkOutput("t3 drained valid", 32'(rsp_valid), 32'd0);
    checkOutput("t3 drained inflight", 32'(inflight), 32'd0);

    // Signs and wrap: (-1.0)*(-1.0) = 1024; 32767*65535 >>> 7 = 16776448, low 18 bits 0x3FD00
    applyReset;
    setOperand(0, 16'(-256), 17'(-512));
    setOperand(1, 16'd32767, 17'd65535);
    applyStimulus(4'b0011, 1'b1, 1'b1);
    checkOutput("t4 ready0", 32'(req_ready), 32'b0001);
    stepEdge;
    applyStimulus(4'b0010, 1'b1, 1'b1);
    checkOutput("t4 ready1", 32'(req_ready), 32'b0010);
    stepEdge;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    stepEdge;
    checkResponse("t4 neg", 1'b1, 2'd0, 18'd1024);
    stepEdge;
    checkResponse("t4 wrap", 1'b1, 2'd1, 18'h3FD00);
    stepEdge;
    checkOutput("t4 drained", 32'(rsp_valid), 32'd0);

    // Drain with en=0, then reset with two ops in flight
    applyReset;
    setOperand(0, 16'd256, 17'd512);
    setOperand(1, 16'd512, 17'd512);
    applyStimulus(4'b0011, 1'b1, 1'b1);
    checkOutput("t5 ready0", 32'(req_ready), 32'b0001);
    stepEdge;
    applyStimulus(4'b0010, 1'b1, 1'b1);
    checkOutput("t5 ready1", 32'(req_ready), 32'b0010);
    stepEdge;
    applyStimulus(4'b0100, 1'b0, 1'b1);
    checkOutput("t5 en0 ready", 32'(req_ready), 32'd0);
    checkOutput("t5 en0 inflight", 32'(inflight), 32'd2);
    stepEdge;
    checkResponse("t5 drain0", 1'b1, 2'd0, 18'd1024);
    checkOutput("t5 en0 ready a", 32'(req_ready), 32'd0);
    stepEdge;
    checkResponse("t5 drain1", 1'b1, 2'd1, 18'd2048);
    stepEdge;
    checkOutput("t5 drained valid", 32'(rsp_valid), 32'd0);
    checkOutput("t5 drained inflight", 32'(inflight), 32'd0);
    checkOutput("t5 en0 ready b", 32'(req_ready), 32'd0);
    applyStimulus(4'b0100, 1'b1, 1'b1);
    checkOutput("t5 en1 ready2", 32'(req_ready), 32'b0100);
    stepEdge;
    applyStimulus(4'b1000, 1'b1, 1'b1);
    checkOutput("t5 en1 ready3", 32'(req_ready), 32'b1000);
    stepEdge;
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("t5 pre-reset inflight", 32'(inflight), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("t5 reset valid", 32'(rsp_valid), 32'd0);
    checkOutput("t5 reset inflight", 32'(inflight), 32'd0);
    stepEdge;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      stepEdge;
      checkOutput($sformatf("t5 no stale%0d", n), 32'(rsp_valid), 32'd0);
    end
    checkOutput("t5 post inflight", 32'(inflight), 32'd0);

    // Pointer back at 0, single requester streaming, sparse wrap, pointer lands on 2
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        applyStimulus(t6Valid[k], 1'b1, 1'b1);
        checkOutput($sformatf("t6 ready%0d", k), 32'(req_ready), 32'(t6Ready[k]));
      end else begin
        applyStimulus(4'b0000, 1'b1, 1'b1);
      end
      stepEdge;
      if (k >= 2) begin
        checkOutput($sformatf("t6 valid%0d", k), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("t6 id%0d", k), 32'(rsp_id), 32'(t6Ids[k - 2]));
      end
    end
    stepEdge;
    checkOutput("t6 drained valid", 32'(rsp_valid), 32'd0);
    checkOutput("t6 drained inflight", 32'(inflight), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
